// File: rtl/host_strm_wr_chunker_if.sv
// Bundles the descriptor, user stream, write-request, output stream and
// completion signals of the host write chunker.
//   master : the chunker side (drives cfg_ready, s_axis_tready, m_req_*, m_axis_*, done_*, busy)
//   slave  : the surrounding environment (drives cfg_*, s_axis_*, m_req_ready, m_axis_tready)
interface host_strm_wr_chunker_if #(
  parameter int unsigned DATA_BITS  = 512,
  parameter int unsigned VADDR_BITS = 48,
  parameter int unsigned LEN_BITS   = 28,
  parameter int unsigned PID_BITS   = 6
);
  localparam int unsigned BB = DATA_BITS / 8;

  // transfer descriptor
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [VADDR_BITS-1:0] cfg_vaddr;
  logic [LEN_BITS-1:0]   cfg_len;
  logic [PID_BITS-1:0]   cfg_pid;

  // user source stream
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [DATA_BITS-1:0]  s_axis_tdata;
  logic [BB-1:0]         s_axis_tkeep;
  logic                  s_axis_tlast;

  // per-chunk write request
  logic                  m_req_valid;
  logic                  m_req_ready;
  logic [VADDR_BITS-1:0] m_req_vaddr;
  logic [LEN_BITS-1:0]   m_req_len;
  logic [PID_BITS-1:0]   m_req_pid;
  logic                  m_req_last;

  // chunked output stream
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic [DATA_BITS-1:0]  m_axis_tdata;
  logic [BB-1:0]         m_axis_tkeep;
  logic                  m_axis_tlast;
  logic [PID_BITS-1:0]   m_axis_tid;

  // completion / status
  logic                  done_valid;
  logic [PID_BITS-1:0]   done_pid;
  logic                  busy;

  modport master (
    input  cfg_valid, cfg_vaddr, cfg_len, cfg_pid,
    output cfg_ready,
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
    output s_axis_tready,
    output m_req_valid, m_req_vaddr, m_req_len, m_req_pid, m_req_last,
    input  m_req_ready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid,
    input  m_axis_tready,
    output done_valid, done_pid, busy
  );

  modport slave (
    output cfg_valid, cfg_vaddr, cfg_len, cfg_pid,
    input  cfg_ready,
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
    input  s_axis_tready,
    input  m_req_valid, m_req_vaddr, m_req_len, m_req_pid, m_req_last,
    output m_req_ready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid,
    output m_axis_tready,
    input  done_valid, done_pid, busy
  );
endinterface

// File: rtl/host_strm_wr_chunker.sv
// Host write stream chunker: splits one configured transfer (vaddr, len, pid)
// into PKT_BYTES chunks, issuing a write request ahead of each chunk and then
// passing that chunk's beats through with regenerated tlast/tkeep.
// Ports:
//   aclk, areset : clock, asynchronous active-high reset
//   bus          : descriptor, user stream in, write request out,
//                  chunk stream out, completion pulse and busy status
module host_strm_wr_chunker #(
  parameter int unsigned DATA_BITS  = 512,
  parameter int unsigned PKT_BYTES  = 4096,
  parameter int unsigned VADDR_BITS = 48,
  parameter int unsigned LEN_BITS   = 28,
  parameter int unsigned PID_BITS   = 6
) (
  input logic                    aclk,
  input logic                    areset,
  host_strm_wr_chunker_if.master bus
);
  localparam int unsigned BB        = DATA_BITS / 8;
  localparam int unsigned BB_LOG2   = $clog2(BB);
  localparam int unsigned BEAT_BITS = $clog2(PKT_BYTES / BB) + 1;

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

  state_t                state, state_nxt;
  logic [VADDR_BITS-1:0] addr, addr_nxt;
  logic [LEN_BITS-1:0]   rem, rem_nxt;
  logic [LEN_BITS-1:0]   chunk, chunk_nxt;
  logic [PID_BITS-1:0]   pid, pid_nxt;
  logic                  last, last_nxt;
  logic [BEAT_BITS-1:0]  beat_cnt, beat_cnt_nxt;
  logic                  req_valid, req_valid_nxt;
  logic                  cfg_rdy, cfg_rdy_nxt;
  logic                  done, done_nxt;
  logic [PID_BITS-1:0]   done_pid_q, done_pid_nxt;
  logic                  busy_q, busy_nxt;

  logic                  in_data;
  logic                  beat_hs;
  logic                  final_beat;
  logic [BB_LOG2-1:0]    tail;
  logic [BB-1:0]         tail_keep;
  logic                  unused_inputs;

  assign in_data    = (state == DATA);
  assign beat_hs    = in_data & bus.s_axis_tvalid & bus.m_axis_tready;
  assign final_beat = (beat_cnt == BEAT_BITS'(1));
  assign tail       = chunk[BB_LOG2-1:0];
  // a chunk that is not a whole number of beats keeps only the low tail bytes
  assign tail_keep  = (tail == '0) ? '1 : ((BB'(1) << tail) - BB'(1));

  // user tkeep/tlast carry no meaning here; chunking is length-driven
  assign unused_inputs = ^{bus.s_axis_tkeep, bus.s_axis_tlast};

  // state and datapath registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      addr       <= '0;
      rem        <= '0;
      chunk      <= '0;
      pid        <= '0;
      last       <= 1'b0;
      beat_cnt   <= '0;
      req_valid  <= 1'b0;
      cfg_rdy    <= 1'b1;
      done       <= 1'b0;
      done_pid_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr       <= addr_nxt;
      rem        <= rem_nxt;
      chunk      <= chunk_nxt;
      pid        <= pid_nxt;
      last       <= last_nxt;
      beat_cnt   <= beat_cnt_nxt;
      req_valid  <= req_valid_nxt;
      cfg_rdy    <= cfg_rdy_nxt;
      done       <= done_nxt;
      done_pid_q <= done_pid_nxt;
      busy_q     <= busy_nxt;
    end
  end

  // next state, datapath updates and registered status outputs
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    rem_nxt      = rem;
    chunk_nxt    = chunk;
    pid_nxt      = pid;
    last_nxt     = last;
    beat_cnt_nxt = beat_cnt;

    case (state)
      IDLE: begin
        if (bus.cfg_valid) begin
          addr_nxt  = bus.cfg_vaddr;
          rem_nxt   = bus.cfg_len;
          pid_nxt   = bus.cfg_pid;
          state_nxt = (bus.cfg_len == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        if (bus.m_req_ready) begin
          // ceil(chunk / BB): whole beats plus one for a partial tail
          beat_cnt_nxt = BEAT_BITS'(chunk >> BB_LOG2) + BEAT_BITS'(|tail);
          state_nxt    = DATA;
        end
      end
      DATA: begin
        if (beat_hs) begin
          beat_cnt_nxt = beat_cnt - BEAT_BITS'(1);
          if (final_beat) begin
            rem_nxt   = rem - chunk;
            addr_nxt  = addr + VADDR_BITS'(chunk);
            state_nxt = last ? DONE : REQ;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // size the next request as it is entered so its fields are stable while valid
    if ((state_nxt == REQ) && (state != REQ)) begin
      chunk_nxt = (rem_nxt > LEN_BITS'(PKT_BYTES)) ? LEN_BITS'(PKT_BYTES) : rem_nxt;
      last_nxt  = (rem_nxt <= LEN_BITS'(PKT_BYTES));
    end

    req_valid_nxt = (state_nxt == REQ);
    cfg_rdy_nxt   = (state_nxt == IDLE);
    busy_nxt      = (state_nxt != IDLE);
    done_nxt      = (state_nxt == DONE);
    done_pid_nxt  = (state_nxt == DONE) ? pid_nxt : '0;
  end

  assign bus.cfg_ready     = cfg_rdy;
  assign bus.busy          = busy_q;
  assign bus.done_valid    = done;
  assign bus.done_pid      = done_pid_q;

  assign bus.m_req_valid   = req_valid;
  assign bus.m_req_vaddr   = addr;
  assign bus.m_req_len     = chunk;
  assign bus.m_req_pid     = pid;
  assign bus.m_req_last    = last;

  // data phase is a straight pass-through gated by the current chunk
  assign bus.s_axis_tready = in_data & bus.m_axis_tready;
  assign bus.m_axis_tvalid = in_data & bus.s_axis_tvalid;
  assign bus.m_axis_tdata  = in_data ? bus.s_axis_tdata : '0;
  assign bus.m_axis_tkeep  = in_data ? (final_beat ? tail_keep : '1) : '0;
  assign bus.m_axis_tlast  = in_data & final_beat;
  assign bus.m_axis_tid    = pid;
endmodule

// File: tb/tb_host_strm_wr_chunker.sv
// Directed bench for host_strm_wr_chunker (default parameters, BB = 64).
module tb_host_strm_wr_chunker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  host_strm_wr_chunker_if b ();

  host_strm_wr_chunker dut (
    .aclk   (clk),
    .areset (rst),
    .bus    (b)
  );

  int    checks   = 0;
  int    failures = 0;
  string tname    = "init";

  // hand-computed request table for the transfer under test
  int          n_req;
  logic [47:0] e_va   [2];
  logic [27:0] e_len  [2];
  logic        e_last [2];
  int          e_beats[2];
  logic [63:0] e_keep [2];

  localparam logic [63:0] KEEP_ALL = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tname, tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pattern(input int k);
    return {16{32'hC0DE_0000 + 32'(k)}};
  endfunction

  task automatic set_req(input int i, input logic [47:0] va, input logic [27:0] ln,
                         input logic lst, input int beats, input logic [63:0] keep);
    e_va[i] = va; e_len[i] = ln; e_last[i] = lst; e_beats[i] = beats; e_keep[i] = keep;
  endtask

  // issue one descriptor and follow it cycle by cycle to its completion
  task automatic run_xfer(input logic [47:0] va, input logic [27:0] ln,
                          input logic [5:0] pd, input bit stall);
    int  req_idx, cur, beats_left, beat_idx, total;
    bit  finished;
    bit  exp_req, exp_done, exp_dv;
    req_idx = 0; cur = 0; beats_left = 0; beat_idx = 0; finished = 1'b0;
    total = 0;
    for (int i = 0; i < n_req; i++) total += e_beats[i];

    @(negedge clk);
    b.cfg_valid = 1'b1; b.cfg_vaddr = va; b.cfg_len = ln; b.cfg_pid = pd;
    b.s_axis_tvalid = 1'b1; b.s_axis_tdata = pattern(0);
    b.m_req_ready = 1'b0; b.m_axis_tready = 1'b0;
    #1 chk("cfg_ready", 512'(b.cfg_ready), 512'(1));

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      b.cfg_valid     = 1'b0;
      b.m_req_ready   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      b.m_axis_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      b.s_axis_tdata  = pattern(beat_idx);
      #1;
      exp_req  = (beats_left == 0) && (req_idx < n_req);
      exp_done = (beats_left == 0) && (req_idx == n_req);
      exp_dv   = (beats_left != 0);
      chk("req_valid", 512'(b.m_req_valid), 512'(exp_req));
      chk("m_tvalid", 512'(b.m_axis_tvalid), 512'(exp_dv));
      chk("s_tready", 512'(b.s_axis_tready), 512'(exp_dv && b.m_axis_tready));
      chk("done_valid", 512'(b.done_valid), 512'(exp_done));
      chk("busy", 512'(b.busy), 512'(1));
      chk("cfg_ready_busy", 512'(b.cfg_ready), 512'(0));
      if (exp_dv) begin
        chk("tdata", b.m_axis_tdata, pattern(beat_idx));
        chk("tid", 512'(b.m_axis_tid), 512'(pd));
        chk("tlast", 512'(b.m_axis_tlast), 512'(beats_left == 1));
        chk("tkeep", 512'(b.m_axis_tkeep), 512'((beats_left == 1) ? e_keep[cur] : KEEP_ALL));
        if (b.m_axis_tready) begin
          beats_left--;
          beat_idx++;
        end
      end else if (exp_req) begin
        chk("req_vaddr", 512'(b.m_req_vaddr), 512'(e_va[req_idx]));
        chk("req_len", 512'(b.m_req_len), 512'(e_len[req_idx]));
        chk("req_pid", 512'(b.m_req_pid), 512'(pd));
        chk("req_last", 512'(b.m_req_last), 512'(e_last[req_idx]));
        if (b.m_req_ready) begin
          cur        = req_idx;
          beats_left = e_beats[req_idx];
          req_idx++;
        end
      end else begin
        chk("done_pid", 512'(b.done_pid), 512'(pd));
        finished = 1'b1;
        break;
      end
    end
    chk("completed_in_budget", 512'(finished), 512'(1));
    chk("beat_total", 512'(beat_idx), 512'(total));

    // back in IDLE: extra input beats stay unconsumed
    b.m_axis_tready = 1'b1;
    b.m_req_ready   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      chk("post_cfg_ready", 512'(b.cfg_ready), 512'(1));
      chk("post_busy", 512'(b.busy), 512'(0));
      chk("post_s_tready", 512'(b.s_axis_tready), 512'(0));
      chk("post_m_tvalid", 512'(b.m_axis_tvalid), 512'(0));
      chk("post_done", 512'(b.done_valid), 512'(0));
      chk("post_req_valid", 512'(b.m_req_valid), 512'(0));
    end
    b.s_axis_tvalid = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_cfg_ready", 512'(b.cfg_ready), 512'(1));
    chk("rst_busy", 512'(b.busy), 512'(0));
    chk("rst_req_valid", 512'(b.m_req_valid), 512'(0));
    chk("rst_req_fields", 512'({b.m_req_vaddr, b.m_req_len, b.m_req_pid, b.m_req_last}), 512'(0));
    chk("rst_m_tvalid", 512'(b.m_axis_tvalid), 512'(0));
    chk("rst_s_tready", 512'(b.s_axis_tready), 512'(0));
    chk("rst_tdata", b.m_axis_tdata, 512'(0));
    chk("rst_tkeep_tlast_tid", 512'({b.m_axis_tkeep, b.m_axis_tlast, b.m_axis_tid}), 512'(0));
    chk("rst_done", 512'({b.done_valid, b.done_pid}), 512'(0));
  endtask

  initial begin
    int cnt;
    b.cfg_valid = 1'b0; b.cfg_vaddr = '0; b.cfg_len = '0; b.cfg_pid = '0;
    b.s_axis_tvalid = 1'b0; b.s_axis_tdata = '0; b.s_axis_tkeep = '0; b.s_axis_tlast = 1'b0;
    b.m_req_ready = 1'b0; b.m_axis_tready = 1'b0;

    tname = "reset";
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    #1 chk_reset_outputs();

    tname = "len8192";
    n_req = 2;
    set_req(0, 48'h1000, 28'd4096, 1'b0, 64, KEEP_ALL);
    set_req(1, 48'h2000, 28'd4096, 1'b1, 64, KEEP_ALL);
    run_xfer(48'h1000, 28'd8192, 6'd3, 1'b0);

    tname = "len100";
    n_req = 1;
    set_req(0, 48'h40, 28'd100, 1'b1, 2, 64'h0000_000F_FFFF_FFFF);
    run_xfer(48'h40, 28'd100, 6'd9, 1'b0);

    tname = "len0";
    n_req = 0;
    run_xfer(48'h123, 28'd0, 6'd5, 1'b0);

    tname = "len5000_stall";
    n_req = 2;
    set_req(0, 48'h10_0000, 28'd4096, 1'b0, 64, KEEP_ALL);
    set_req(1, 48'h10_1000, 28'd904, 1'b1, 15, 64'h0000_0000_0000_00FF);
    run_xfer(48'h10_0000, 28'd5000, 6'd12, 1'b1);

    tname = "reset_mid";
    @(negedge clk);
    b.cfg_valid = 1'b1; b.cfg_vaddr = 48'h1000; b.cfg_len = 28'd8192; b.cfg_pid = 6'd3;
    b.s_axis_tvalid = 1'b1; b.m_req_ready = 1'b1; b.m_axis_tready = 1'b1;
    cnt = 0;
    for (int cyc = 0; cyc < 200 && cnt < 30; cyc++) begin
      @(negedge clk);
      b.cfg_valid = 1'b0;
      b.s_axis_tdata = pattern(cnt);
      #1 if (b.m_axis_tvalid && b.m_axis_tready) cnt++;
    end
    chk("beats_before_reset", 512'(cnt), 512'(30));
    @(negedge clk);
    b.s_axis_tdata = pattern(30);
    #1 chk("beat30_presented", 512'(b.m_axis_tvalid), 512'(1));
    rst = 1'b1;
    #1 chk_reset_outputs();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1 chk_reset_outputs();
    end
    rst = 1'b0;
    b.s_axis_tvalid = 1'b0;
    @(negedge clk);
    #1 chk("after_reset_no_done", 512'(b.done_valid), 512'(0));
    chk("after_reset_idle", 512'(b.cfg_ready), 512'(1));

    tname = "len64_after_reset";
    n_req = 1;
    set_req(0, 48'h8000, 28'd64, 1'b1, 1, KEEP_ALL);
    run_xfer(48'h8000, 28'd64, 6'd7, 1'b0);

    tname = "len128_extra";
    n_req = 1;
    set_req(0, 48'h0000_0002_0000, 28'd128, 1'b1, 2, KEEP_ALL);
    run_xfer(48'h0000_0002_0000, 28'd128, 6'd33, 1'b0);

    tname = "addr_wrap";
    n_req = 2;
    set_req(0, 48'hFFFF_FFFF_F000, 28'd4096, 1'b0, 64, KEEP_ALL);
    set_req(1, 48'h0000_0000_0000, 28'd64, 1'b1, 1, KEEP_ALL);
    run_xfer(48'hFFFF_FFFF_F000, 28'd4160, 6'd63, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
